// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling at BAUD_DIV clocks per bit.
// Received bytes appear on data_out with a one-cycle rx_valid strobe; a low stop bit gives a frame_err strobe.
module uart_rx #(
    parameter int BAUD_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic          sync1, rx_s, rx_s_d;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [7:0]    shift, shift_next, data_next;
    logic          valid_next, ferr_next;

    // Output protocol: rx_valid and frame_err are single-cycle strobes with no ready/backpressure;
    // data_out holds the last good byte until the next rx_valid, so a consumer may read it any time after.
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            sync1  <= rx;
            rx_s   <= sync1;
            rx_s_d <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= 8'h00;
            data_out  <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shift     <= shift_next;
            data_out  <= data_next;
            rx_valid  <= valid_next;
            frame_err <= ferr_next;
            rx_busy   <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        data_next  = data_out;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        unique case (state)
            IDLE: begin
                // Needs a high-to-low transition, so a line held low cannot restart a frame.
                if (rx_s_d && !rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    if (!rx_s) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    shift_next[idx] = rx_s;
                    cnt_next        = '0;
                    if (idx == 3'd7) state_next = STOP;
                    else             idx_next   = idx + 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (BAUD_DIV 4, 2, 12) on one clock, directed and random frames.
// Each issued frame pushes its expected outcome and arrival cycle; a negedge monitor pops and compares.
module tb_uart_rx;
    localparam int N_INST = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_l      [N_INST];
    logic [7:0] dout      [N_INST];
    logic       vld       [N_INST];
    logic       bsy       [N_INST];
    logic       ferr      [N_INST];
    logic [1:0] st        [N_INST];
    logic [7:0] last_good [N_INST];
    logic [7:0] prev_dout [N_INST];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    // Entry: {is_frame_err, expected data_out, cycle of the strobe}
    logic [40:0] exp_q0[$];
    logic [40:0] exp_q1[$];
    logic [40:0] exp_q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx #(.BAUD_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .rx(rx_l[0]), .data_out(dout[0]), .rx_valid(vld[0]),
        .rx_busy(bsy[0]), .frame_err(ferr[0]), .state_dbg(st[0])
    );
    uart_rx #(.BAUD_DIV(2)) u_dut2 (
        .clk(clk), .reset(reset), .rx(rx_l[1]), .data_out(dout[1]), .rx_valid(vld[1]),
        .rx_busy(bsy[1]), .frame_err(ferr[1]), .state_dbg(st[1])
    );
    uart_rx #(.BAUD_DIV(12)) u_dut12 (
        .clk(clk), .reset(reset), .rx(rx_l[2]), .data_out(dout[2]), .rx_valid(vld[2]),
        .rx_busy(bsy[2]), .frame_err(ferr[2]), .state_dbg(st[2])
    );

    function automatic int bdiv(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 12;
        endcase
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic push_exp(input int k, input logic [40:0] e);
        case (k)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output logic [40:0] e);
        case (k)
            0:       e = exp_q0.pop_front();
            1:       e = exp_q1.pop_front();
            default: e = exp_q2.pop_front();
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Must be called at a negedge; returns at the negedge after the stop bit period.
    // The strobe lands 2 sync cycles + 1 detect cycle + half a bit + 9 bits after the start bit is driven.
    task automatic send_frame(input int k, input logic [7:0] b, input logic stop_bit);
        int          bd;
        logic [9:0]  fr;
        logic [31:0] t;
        bd = bdiv(k);
        fr = {stop_bit, b, 1'b0};
        t  = 32'(cyc + 3 + bd / 2 + 9 * bd);
        push_exp(k, {~stop_bit, (stop_bit ? b : last_good[k]), t});
        if (stop_bit) last_good[k] = b;
        for (int i = 0; i < 10; i++) begin
            rx_l[k] = fr[i];
            repeat (bd) @(negedge clk);
        end
    endtask

    task automatic idle(input int k, input int n);
        rx_l[k] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic monitor_inst(input int k);
        logic [40:0] e;
        if (vld[k] === 1'b1 && ferr[k] === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL pulse_overlap inst=%0d rx_valid=1 frame_err=1 required never both", k);
        end
        if (vld[k] === 1'b1 || ferr[k] === 1'b1) begin
            checks++;
            if (q_size(k) == 0) begin
                failures++;
                $display("FAIL unexpected_pulse inst=%0d cyc=%0d rx_valid=%0b frame_err=%0b data_out=%02h required no pulse",
                         k, cyc, vld[k], ferr[k], dout[k]);
            end else begin
                pop_exp(k, e);
                if (ferr[k] !== e[40] || vld[k] !== ~e[40] || dout[k] !== e[39:32] || 32'(cyc) !== e[31:0]) begin
                    failures++;
                    $display("FAIL frame_event inst=%0d actual: frame_err=%0b rx_valid=%0b data_out=%02h cyc=%0d required: frame_err=%0b data_out=%02h cyc=%0d",
                             k, ferr[k], vld[k], dout[k], cyc, e[40], e[39:32], e[31:0]);
                end
            end
        end else if (dout[k] !== prev_dout[k]) begin
            checks++;
            failures++;
            $display("FAIL data_out_stable inst=%0d actual=%02h required=%02h", k, dout[k], prev_dout[k]);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int k = 0; k < N_INST; k++) monitor_inst(k);
        end
        for (int k = 0; k < N_INST; k++) prev_dout[k] = dout[k];
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] fr;
        int         k;
        logic [7:0] b;
        logic       good;
        reset = 1'b1;
        for (int i = 0; i < N_INST; i++) begin
            rx_l[i]      = 1'b1;
            last_good[i] = 8'h00;
            prev_dout[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(dout[0]), 32'h0);
        check("reset_rx_valid", 32'(vld[0]), 32'h0);
        check("reset_rx_busy", 32'(bsy[0]), 32'h0);
        check("reset_frame_err", 32'(ferr[0]), 32'h0);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single good frame, busy sampled mid-frame
        fork
            send_frame(0, 8'h05, 1'b1);
            begin
                repeat (20) @(negedge clk);
                check("busy_mid_frame", 32'(bsy[0]), 32'h1);
                check("no_ferr_mid_frame", 32'(ferr[0]), 32'h0);
            end
        join
        idle(0, 8);
        check("busy_after_frame", 32'(bsy[0]), 32'h0);
        check("drained_0x05", 32'(q_size(0)), 32'h0);

        // Back-to-back frames with no idle gap
        send_frame(0, 8'h3C, 1'b1);
        send_frame(0, 8'hA5, 1'b1);
        idle(0, 8);
        check("drained_b2b", 32'(q_size(0)), 32'h0);
        check("data_after_b2b", 32'(dout[0]), 32'hA5);

        // False start: one clock of low
        rx_l[0] = 1'b0;
        @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("false_start_busy_rise", 32'(bsy[0]), 32'h1);
        repeat (bdiv(0) / 2 + 1) @(negedge clk);
        check("false_start_busy_drop", 32'(bsy[0]), 32'h0);
        idle(0, 8);

        // Bad stop bit, line then held low
        send_frame(0, 8'hFF, 1'b0);
        repeat (40) @(negedge clk);
        check("stuck_low_no_retrigger", 32'(bsy[0]), 32'h0);
        check("data_kept_after_ferr", 32'(dout[0]), 32'(last_good[0]));
        idle(0, 8);
        send_frame(0, 8'hC3, 1'b1);
        idle(0, 8);

        // Reset during data bit 3 of 0x55
        fr = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_l[0] = fr[i];
            repeat ((i == 4) ? 2 : 4) @(negedge clk);
        end
        check("busy_before_reset", 32'(bsy[0]), 32'h1);
        #1 reset = 1'b1;
        rx_l[0] = 1'b1;
        @(negedge clk);
        check("midreset_data_out", 32'(dout[0]), 32'h0);
        check("midreset_rx_valid", 32'(vld[0]), 32'h0);
        check("midreset_rx_busy", 32'(bsy[0]), 32'h0);
        check("midreset_frame_err", 32'(ferr[0]), 32'h0);
        for (int i = 0; i < N_INST; i++) last_good[i] = 8'h00;
        @(negedge clk);
        #1 reset = 1'b0;
        idle(0, 8);
        send_frame(0, 8'h81, 1'b1);
        idle(0, 8);
        check("data_after_reset_frame", 32'(dout[0]), 32'h81);

        // Other bit rates
        send_frame(1, 8'h05, 1'b1);
        idle(1, 6);
        send_frame(2, 8'h05, 1'b1);
        idle(2, 6);

        // Random traffic across all receivers
        for (int n = 0; n < 24; n++) begin
            k    = int'($urandom_range(0, 2));
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 5) != 0);
            send_frame(k, b, good);
            if (good) idle(k, int'($urandom_range(0, 2 * bdiv(k))));
            else      idle(k, bdiv(k) + int'($urandom_range(0, bdiv(k))));
        end

        for (int w = 0; w < 400 && (q_size(0) + q_size(1) + q_size(2)) != 0; w++) @(negedge clk);
        check("drained_end_inst0", 32'(q_size(0)), 32'h0);
        check("drained_end_inst1", 32'(q_size(1)), 32'h0);
        check("drained_end_inst2", 32'(q_size(2)), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2, meaning clock cycles per serial bit; legal range is 2 to 65535.
REQ-002 Port clk, input, 1 bit, meaning the system clock; all logic is on its rising edge.
REQ-003 Port reset, input, 1 bit, meaning an asynchronous, active-high reset.
REQ-004 Port rx, input, 1 bit, meaning the asynchronous serial line; it idles high.
REQ-005 Port data_out, output, 8 bits, meaning the last correctly framed byte received.
REQ-006 Port rx_valid, output, 1 bit, meaning a one-cycle pulse indicating that data_out has just been updated.
REQ-007 Port rx_busy, output, 1 bit, meaning a frame is in progress.
REQ-008 Port frame_err, output, 1 bit, meaning a one-cycle pulse indicating that the stop bit was sampled low.

Function
REQ-009 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, 1 stop bit (1), with no parity.
REQ-010 rx SHALL pass through a 2-flop synchronizer; rx_s is its output, and the synchronizer flops reset to 1.
REQ-011 The FSM SHALL have the states IDLE, START, DATA and STOP; rx_busy SHALL be 1 exactly when the state is not IDLE (registered).
REQ-012 IDLE: a falling edge on rx_s (previous rx_s=1, current rx_s=0) SHALL move the FSM to START and clear the bit-timing counter.
  - Transition requires a prior high, so a line stuck low never retriggers.
REQ-013 START: the counter increments each cycle; at counter == BAUD_DIV/2-1 (integer division), rx_s is sampled.
  - rx_s = 0: go to DATA, clear counter, bit index = 0.
  - rx_s = 1: false start; return to IDLE with no output pulse.
REQ-014 DATA: at counter == BAUD_DIV-1, rx_s is shifted into bit[index] and the counter is cleared.
  - After index 7, go to STOP; otherwise increment index.
REQ-015 STOP: at counter == BAUD_DIV-1, rx_s is sampled and the FSM returns to IDLE.
  - rx_s = 1: data_out <= assembled byte; rx_valid = 1 for exactly one cycle.
  - rx_s = 0: frame_err = 1 for one cycle; data_out keeps its previous value; rx_valid stays 0.
REQ-016 rx_valid and frame_err SHALL be registered, never asserted together, and each high for exactly one clk cycle per frame.
REQ-017 Latency: rx_valid SHALL rise on the clock edge following the stop-bit sample, which is (BAUD_DIV/2) + 9*BAUD_DIV + 1 cycles after the falling edge on rx_s.
REQ-018 Back-to-back frames, where a start bit immediately follows the stop bit, SHALL be received without loss, since IDLE is re-entered before the next falling edge.
REQ-019 The counter width SHALL be clog2(BAUD_DIV) bits; it SHALL never wrap inside a bit period, and the index SHALL be 3 bits.
REQ-020 data_out SHALL remain stable between rx_valid pulses and be valid from the cycle rx_valid is high onward.
REQ-021 rx activity while in START/DATA/STOP, other than at sample points, SHALL be ignored; no oversampling or majority vote is performed.

Reset
REQ-022 Asserting reset SHALL immediately force:
  - state = IDLE, counter = 0, index = 0;
  - shift register = 0x00, data_out = 0x00;
  - rx_valid = 0, rx_busy = 0, frame_err = 0;
  - synchronizer flops = 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte with no rx_valid or frame_err pulse; after release, the FSM SHALL wait for a new falling edge (high then low).
REQ-024 reset SHALL take priority over every other event in the same cycle.

Verification (BAUD_DIV=4, clk 50 MHz, bits driven for 4 cycles each)
REQ-025 Send 0x05 framed correctly -> exactly one rx_valid pulse with data_out=0x05; rx_busy high for the frame duration; frame_err=0.
REQ-026 Send 0x3C immediately followed by 0xA5 with no idle gap -> two rx_valid pulses with data_out 0x3C then 0xA5.
REQ-027 Drive rx low for 1 clk, then high -> false start; FSM returns to IDLE; no rx_valid and no frame_err; rx_busy drops within BAUD_DIV/2+1 cycles.
REQ-028 Send 0xFF with stop bit = 0 and hold rx low -> one frame_err pulse; data_out unchanged from the previous byte; no retrigger until rx returns high and falls again.
REQ-029 Assert reset during data bit 3 of 0x55, release, then send 0x81 -> all outputs at reset values during reset; no pulse for 0x55; rx_valid with data_out=0x81.
REQ-030 Repeat REQ-025 with BAUD_DIV=2 and BAUD_DIV=12 -> correct byte and REQ-017 latency in each case.
